alu_sequencer: RTL and testbench

- Multi-cycle initiator that drives the registered N-bit ALU (OP/A/B/en/rst in; Result/ONZ out, both one-cycle registered) from a stream of decoded instructions.
- Owns an 8-entry register file that supplies the operands, writes ALU results back, loads immediates, and resolves conditional branches on the ALU's O/N/Z flags.
- Sits between the instruction decode stage and the ALU inside the datapath.

---
 rtl/alu_sequencer_if.sv | 28 ++
 rtl/alu_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Instruction channel between the decode stage and the ALU sequencer.
// The decode stage drives the decoded fields plus a valid flag. The sequencer
// answers with ready. A transfer happens on a rising edge where both are high.
interface alu_sequencer_if #(
    parameter int N = 8
);
    logic         instr_valid;
    logic         instr_ready;
    logic [1:0]   instr_kind;
    logic [2:0]   instr_op;
    logic [2:0]   instr_rd;
    logic [2:0]   instr_ra;
    logic [2:0]   instr_rb;
    logic [N-1:0] instr_imm;
    logic [1:0]   instr_cond;

    modport master (
        output instr_valid, instr_kind, instr_op, instr_rd, instr_ra,
               instr_rb, instr_imm, instr_cond,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_kind, instr_op, instr_rd, instr_ra,
               instr_rb, instr_imm, instr_cond,
        output instr_ready
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer that feeds a registered ALU from decoded instructions.
// It owns an 8-entry register file that supplies the operands, takes ALU
// write-backs and immediate loads, and resolves branches on the ALU flags.
module alu_sequencer #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           arstn,
    alu_sequencer_if.slave instrBus,
    output logic [2:0]     alu_op,
    output logic [N-1:0]   alu_a,
    output logic [N-1:0]   alu_b,
    output logic           alu_en,
    output logic           alu_rst,
    input  logic [N-1:0]   alu_result,
    input  logic [2:0]     alu_onz,
    output logic           br_valid,
    output logic           br_taken,
    output logic [N-1:0]   br_target,
    output logic           done,
    input  logic [2:0]     dbg_addr,
    output logic [N-1:0]   dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [1:0] KIND_ALU  = 2'b00;
    localparam logic [1:0] KIND_LDI  = 2'b01;
    localparam logic [1:0] KIND_BR   = 2'b10;
    localparam logic [1:0] KIND_CLRF = 2'b11;

    state_t       state_q, state_d;
    logic [1:0]   kind_q;
    logic [2:0]   rd_q;
    logic [N-1:0] imm_q;
    logic [1:0]   cond_q;
    logic [2:0]   aluOp_q;
    logic [N-1:0] aluA_q;
    logic [N-1:0] aluB_q;
    logic [N-1:0] rf_q [8];
    logic         accept;
    logic         rfWe;
    logic [N-1:0] rfWdata;

    assign instrBus.instr_ready = (state_q == IDLE);
    assign accept   = instrBus.instr_valid && (state_q == IDLE);
    assign alu_op   = aluOp_q;
    assign alu_a    = aluA_q;
    assign alu_b    = aluB_q;
    assign dbg_data = rf_q[dbg_addr];

    // State register; reset returns to IDLE and aborts any instruction in flight.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle strobes. ALU work takes an extra WB cycle; every other kind retires in EXEC.
    always_comb begin
        state_d   = state_q;
        alu_en    = 1'b0;
        alu_rst   = 1'b0;
        br_valid  = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        done      = 1'b0;
        rfWe      = 1'b0;
        rfWdata   = alu_result;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = IDLE;
                case (kind_q)
                    KIND_ALU: begin
                        alu_en  = 1'b1;
                        state_d = WB;
                    end
                    KIND_LDI: begin
                        rfWe    = 1'b1;
                        rfWdata = imm_q;
                        done    = 1'b1;
                    end
                    KIND_BR: begin
                        br_valid  = 1'b1;
                        br_taken  = (cond_q == 2'b00)
                                  | ((cond_q == 2'b01) & alu_onz[0])
                                  | ((cond_q == 2'b10) & alu_onz[1])
                                  | ((cond_q == 2'b11) & alu_onz[2]);
                        br_target = imm_q;
                        done      = 1'b1;
                    end
                    default: begin
                        alu_rst = 1'b1;
                        done    = 1'b1;
                    end
                endcase
            end
            WB: begin
                rfWe    = 1'b1;
                rfWdata = alu_result;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the instruction on accept. ALU operands are read here because
    // no register write can land between accept and EXEC. The ALU drive
    // registers only change for ALU instructions, so they hold the last driven value.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            kind_q  <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            cond_q  <= '0;
            aluOp_q <= '0;
            aluA_q  <= '0;
            aluB_q  <= '0;
        end else if (accept) begin
            kind_q <= instrBus.instr_kind;
            rd_q   <= instrBus.instr_rd;
            imm_q  <= instrBus.instr_imm;
            cond_q <= instrBus.instr_cond;
            if (instrBus.instr_kind == KIND_ALU) begin
                aluOp_q <= instrBus.instr_op;
                aluA_q  <= rf_q[instrBus.instr_ra];
                aluB_q  <= rf_q[instrBus.instr_rb];
            end
        end
    end

    // Register file write port: immediate loads in EXEC, ALU results in WB.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rfWe) begin
            rf_q[rd_q] <= rfWdata;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural registered ALU.
module tb_alu_sequencer;

    localparam int N = 8;
    localparam logic [1:0] K_ALU  = 2'b00;
    localparam logic [1:0] K_LDI  = 2'b01;
    localparam logic [1:0] K_BR   = 2'b10;
    localparam logic [1:0] K_CLRF = 2'b11;

    typedef struct {
        logic [1:0] kind;
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] imm;
        logic [1:0] cond;
        logic [7:0] expVal;
        logic [2:0] expOnz;
        logic       expTaken;
    } vec_t;

    typedef struct {
        logic [1:0] kind;
        logic [2:0] rd;
        logic [7:0] val;
        logic [2:0] onz;
        logic       taken;
        logic [7:0] target;
    } exp_t;

    logic         clk = 1'b0;
    logic         arstn;
    logic [2:0]   alu_op;
    logic [N-1:0] alu_a, alu_b;
    logic         alu_en, alu_rst;
    logic [N-1:0] alu_result;
    logic [2:0]   alu_onz;
    logic         br_valid, br_taken;
    logic [N-1:0] br_target;
    logic         done;
    logic [2:0]   dbg_addr;
    logic [N-1:0] dbg_data;
    logic [10:0]  aluNext;

    int   errors = 0;
    int   checks = 0;
    int   doneCount = 0;
    exp_t sbQ[$];
    exp_t monE;
    logic [7:0] expRf [8];
    vec_t vecs [20];
    vec_t b2b [3];

    alu_sequencer_if #(.N(N)) ifc();

    alu_sequencer #(.N(N)) dut (
        .clk        (clk),
        .arstn      (arstn),
        .instrBus   (ifc),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_en     (alu_en),
        .alu_rst    (alu_rst),
        .alu_result (alu_result),
        .alu_onz    (alu_onz),
        .br_valid   (br_valid),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .done       (done),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    // Reference ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A, 7 pass B; returns {O,N,Z,result}
    function automatic logic [10:0] aluCalc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic       o;
        o = 1'b0;
        case (op)
            3'd0: begin r = a + b; o = (a[7] == b[7]) && (r[7] != a[7]); end
            3'd1: begin r = a - b; o = (a[7] != b[7]) && (r[7] != a[7]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: r = {a[6:0], 1'b0};
            default: r = b;
        endcase
        return {o, r[7], (r == 8'h00), r};
    endfunction

    // Combinational part of the reference ALU
    always_comb aluNext = aluCalc(alu_op, alu_a, alu_b);

    // Registered reference ALU: result and flags update on en, flags clear on rst
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            alu_result <= '0;
            alu_onz    <= '0;
        end else if (alu_rst) begin
            alu_onz <= '0;
        end else if (alu_en) begin
            alu_result <= aluNext[7:0];
            alu_onz    <= aluNext[10:8];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] kind, input logic [2:0] op, input logic [2:0] rd,
                                input logic [2:0] ra, input logic [2:0] rb, input logic [7:0] imm,
                                input logic [1:0] cond, input logic [7:0] expVal,
                                input logic [2:0] expOnz, input logic expTaken);
        vec_t v;
        v.kind = kind; v.op = op; v.rd = rd; v.ra = ra; v.rb = rb; v.imm = imm;
        v.cond = cond; v.expVal = expVal; v.expOnz = expOnz; v.expTaken = expTaken;
        return v;
    endfunction

    // Scoreboard monitor: every done pulse pops one expectation and checks it
    always @(negedge clk) begin
        if (arstn === 1'b1) begin
            if (br_valid === 1'b1 && done !== 1'b1) begin
                checkOutput("br_valid_without_done", done, 1);
            end
            if (done === 1'b1) begin
                doneCount++;
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_done", done, 0);
                end else begin
                    monE = sbQ.pop_front();
                    checkOutput("br_valid", br_valid, (monE.kind == K_BR));
                    if (monE.kind == K_BR) begin
                        checkOutput("br_taken", br_taken, monE.taken);
                        checkOutput("br_target", br_target, monE.target);
                    end
                    if (monE.kind == K_ALU) begin
                        checkOutput("alu_result", alu_result, monE.val);
                        checkOutput("alu_onz", alu_onz, monE.onz);
                    end
                    if (monE.kind == K_ALU || monE.kind == K_LDI) begin
                        expRf[monE.rd] = monE.val;
                    end
                end
            end
        end
    end

    task automatic driveFields(input vec_t v);
        ifc.instr_kind = v.kind;
        ifc.instr_op   = v.op;
        ifc.instr_rd   = v.rd;
        ifc.instr_ra   = v.ra;
        ifc.instr_rb   = v.rb;
        ifc.instr_imm  = v.imm;
        ifc.instr_cond = v.cond;
    endtask

    task automatic driveGarbage();
        ifc.instr_kind = 2'($urandom);
        ifc.instr_op   = 3'($urandom);
        ifc.instr_rd   = 3'($urandom);
        ifc.instr_ra   = 3'($urandom);
        ifc.instr_rb   = 3'($urandom);
        ifc.instr_imm  = 8'($urandom);
        ifc.instr_cond = 2'($urandom);
    endtask

    task automatic pushExpected(input vec_t v);
        exp_t e;
        e.kind   = v.kind;
        e.rd     = v.rd;
        e.val    = (v.kind == K_LDI) ? v.imm : v.expVal;
        e.onz    = v.expOnz;
        e.taken  = v.expTaken;
        e.target = v.imm;
        sbQ.push_back(e);
    endtask

    task automatic waitReady();
        int n;
        n = 0;
        while (ifc.instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) checkOutput("ready_timeout", ifc.instr_ready, 1);
    endtask

    // One instruction with per-cycle timing checks around the accept edge
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        waitReady();
        driveFields(v);
        ifc.instr_valid = 1'b1;
        pushExpected(v);
        @(posedge clk);
        #1;
        ifc.instr_valid = 1'b0;
        driveGarbage();
        @(negedge clk);
        checkOutput("ready_low_exec", ifc.instr_ready, 0);
        checkOutput("alu_rst_exec", alu_rst, (v.kind == K_CLRF));
        if (v.kind == K_ALU) begin
            checkOutput("alu_en_exec", alu_en, 1);
            checkOutput("alu_op_exec", alu_op, v.op);
            checkOutput("alu_a_exec", alu_a, expRf[v.ra]);
            checkOutput("alu_b_exec", alu_b, expRf[v.rb]);
            checkOutput("done_exec_alu", done, 0);
            @(negedge clk);
            checkOutput("ready_low_wb", ifc.instr_ready, 0);
            checkOutput("alu_en_wb", alu_en, 0);
            checkOutput("done_wb", done, 1);
        end else begin
            checkOutput("alu_en_exec", alu_en, 0);
            checkOutput("done_exec", done, 1);
        end
        @(negedge clk);
        checkOutput("ready_after", ifc.instr_ready, 1);
        checkOutput("done_after", done, 0);
    endtask

    // Sweep the debug port against the expected register file
    task automatic checkRf();
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            checkOutput($sformatf("rf%0d", i), dbg_data, expRf[i]);
        end
    endtask

    task automatic clearExpRf();
        for (int i = 0; i < 8; i++) expRf[i] = 8'h00;
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int doneBefore;
        int idx;
        int cyc;
        int acceptCyc [3];
        vec_t v;

        vecs[0]  = mk(K_LDI,  3'd0, 3'd1, 3'd0, 3'd0, 8'h05, 2'b00, 8'h00, 3'b000, 1'b0);
        vecs[1]  = mk(K_LDI,  3'd0, 3'd2, 3'd0, 3'd0, 8'h03, 2'b00, 8'h00, 3'b000, 1'b0);
        vecs[2]  = mk(K_ALU,  3'd0, 3'd3, 3'd1, 3'd2, 8'h00, 2'b00, 8'h08, 3'b000, 1'b0);
        vecs[3]  = mk(K_LDI,  3'd0, 3'd1, 3'd0, 3'd0, 8'h7F, 2'b00, 8'h00, 3'b000, 1'b0);
        vecs[4]  = mk(K_LDI,  3'd0, 3'd2, 3'd0, 3'd0, 8'h01, 2'b00, 8'h00, 3'b000, 1'b0);
        vecs[5]  = mk(K_ALU,  3'd0, 3'd4, 3'd1, 3'd2, 8'h00, 2'b00, 8'h80, 3'b110, 1'b0);
        vecs[6]  = mk(K_BR,   3'd0, 3'd0, 3'd0, 3'd0, 8'h20, 2'b11, 8'h00, 3'b000, 1'b1);
        vecs[7]  = mk(K_BR,   3'd0, 3'd0, 3'd0, 3'd0, 8'h30, 2'b01, 8'h00, 3'b000, 1'b0);
        vecs[8]  = mk(K_LDI,  3'd0, 3'd1, 3'd0, 3'd0, 8'h05, 2'b00, 8'h00, 3'b000, 1'b0);
        vecs[9]  = mk(K_ALU,  3'd1, 3'd1, 3'd1, 3'd1, 8'h00, 2'b00, 8'h00, 3'b001, 1'b0);
        vecs[10] = mk(K_BR,   3'd0, 3'd0, 3'd0, 3'd0, 8'h44, 2'b01, 8'h00, 3'b000, 1'b1);
        vecs[11] = mk(K_BR,   3'd0, 3'd0, 3'd0, 3'd0, 8'h45, 2'b10, 8'h00, 3'b000, 1'b0);
        vecs[12] = mk(K_CLRF, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 2'b00, 8'h00, 3'b000, 1'b0);
        vecs[13] = mk(K_BR,   3'd0, 3'd0, 3'd0, 3'd0, 8'h50, 2'b01, 8'h00, 3'b000, 1'b0);
        vecs[14] = mk(K_BR,   3'd0, 3'd0, 3'd0, 3'd0, 8'h60, 2'b00, 8'h00, 3'b000, 1'b1);
        vecs[15] = mk(K_ALU,  3'd4, 3'd5, 3'd3, 3'd4, 8'h00, 2'b00, 8'h88, 3'b010, 1'b0);
        vecs[16] = mk(K_BR,   3'd0, 3'd0, 3'd0, 3'd0, 8'h70, 2'b10, 8'h00, 3'b000, 1'b1);
        vecs[17] = mk(K_ALU,  3'd2, 3'd6, 3'd5, 3'd3, 8'h00, 2'b00, 8'h08, 3'b000, 1'b0);
        vecs[18] = mk(K_ALU,  3'd0, 3'd7, 3'd4, 3'd4, 8'h00, 2'b00, 8'h00, 3'b101, 1'b0);
        vecs[19] = mk(K_BR,   3'd0, 3'd0, 3'd0, 3'd0, 8'h7C, 2'b11, 8'h00, 3'b000, 1'b1);

        b2b[0] = mk(K_ALU, 3'd0, 3'd5, 3'd2, 3'd3, 8'h00, 2'b00, 8'h09, 3'b000, 1'b0);
        b2b[1] = mk(K_LDI, 3'd0, 3'd6, 3'd0, 3'd0, 8'hA5, 2'b00, 8'h00, 3'b000, 1'b0);
        b2b[2] = mk(K_BR,  3'd0, 3'd0, 3'd0, 3'd0, 8'h99, 2'b00, 8'h00, 3'b000, 1'b1);

        // Initial reset: all outputs quiet, register file zero
        arstn = 1'b0;
        ifc.instr_valid = 1'b0;
        driveFields(mk(K_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        dbg_addr = 3'd0;
        clearExpRf();
        repeat (3) @(negedge clk);
        checkOutput("rst_alu_op", alu_op, 0);
        checkOutput("rst_alu_a", alu_a, 0);
        checkOutput("rst_alu_b", alu_b, 0);
        checkOutput("rst_alu_en", alu_en, 0);
        checkOutput("rst_alu_rst", alu_rst, 0);
        checkOutput("rst_br_valid", br_valid, 0);
        checkOutput("rst_br_taken", br_taken, 0);
        checkOutput("rst_br_target", br_target, 0);
        checkOutput("rst_done", done, 0);
        arstn = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", ifc.instr_ready, 1);
        checkRf();

        // Reset in the middle of an ALU instruction aborts it
        applyStimulus(mk(K_LDI, 3'd0, 3'd1, 3'd0, 3'd0, 8'h33, 2'b00, 8'h00, 3'b000, 1'b0));
        @(negedge clk);
        v = mk(K_ALU, 3'd0, 3'd2, 3'd1, 3'd1, 8'h00, 2'b00, 8'h66, 3'b000, 1'b0);
        driveFields(v);
        ifc.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        ifc.instr_valid = 1'b0;
        doneBefore = doneCount;
        @(negedge clk);
        checkOutput("abort_alu_a_before", alu_a, 8'h33);
        arstn = 1'b0;
        #1;
        checkOutput("abort_alu_en", alu_en, 0);
        checkOutput("abort_alu_a", alu_a, 0);
        checkOutput("abort_done", done, 0);
        repeat (2) @(negedge clk);
        arstn = 1'b1;
        clearExpRf();
        repeat (3) @(negedge clk);
        checkOutput("abort_no_done", doneCount, doneBefore);
        checkOutput("abort_ready", ifc.instr_ready, 1);
        checkRf();

        // Table-driven instruction stream
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i]);
        end
        @(negedge clk);
        checkRf();

        // Back-to-back with valid held high; fields shown while busy are noise
        doneBefore = doneCount;
        idx = 0;
        cyc = 0;
        @(negedge clk);
        ifc.instr_valid = 1'b1;
        while (idx < 3 && cyc < 40) begin
            if (ifc.instr_ready === 1'b1) begin
                driveFields(b2b[idx]);
                pushExpected(b2b[idx]);
                acceptCyc[idx] = cyc;
                idx++;
            end else begin
                driveGarbage();
            end
            @(negedge clk);
            cyc++;
        end
        ifc.instr_valid = 1'b0;
        checkOutput("b2b_all_accepted", idx, 3);
        checkOutput("b2b_gap_alu", acceptCyc[1] - acceptCyc[0], 3);
        checkOutput("b2b_gap_ldi", acceptCyc[2] - acceptCyc[1], 2);
        cyc = 0;
        while (sbQ.size() != 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("sb_drained", sbQ.size(), 0);
        repeat (2) @(negedge clk);
        checkOutput("b2b_done_count", doneCount - doneBefore, 3);
        checkRf();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
